// File: rtl/cla_group_carry_pipe.sv
// Two-stage 64-bit carry-lookahead carry network (16 groups x 4 bits), latency 2, valid/ready handshake.
// Stage 1 forms 4-group block terms; stage 2 forms block and group carries. A full pipe stalls in_ready.
module cla_group_carry_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] g_grp,
    input  logic [15:0] p_grp,
    input  logic        cin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] c_grp,
    output logic        cout,
    output logic        g_all,
    output logic        p_all
);

    logic        s1_v;
    logic [15:0] s1_g;
    logic [15:0] s1_p;
    logic        s1_cin;
    logic [3:0]  s1_bg;
    logic [3:0]  s1_bp;

    logic        s2_load;
    logic        s1_load;
    logic [3:0]  bg_d;
    logic [3:0]  bp_d;
    logic [4:0]  cb;
    logic [15:0] c_d;
    logic        g_all_d;
    logic        p_all_d;

    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_v || s2_load;
    assign in_ready = s1_load;

    // 4-group lookahead terms over groups 4k..4k+3
    always_comb begin
        bg_d = '0;
        bp_d = '0;
        for (int k = 0; k < 4; k++) begin
            bg_d[k] = g_grp[4*k+3]
                    | (p_grp[4*k+3] & g_grp[4*k+2])
                    | (p_grp[4*k+3] & p_grp[4*k+2] & g_grp[4*k+1])
                    | (p_grp[4*k+3] & p_grp[4*k+2] & p_grp[4*k+1] & g_grp[4*k]);
            bp_d[k] = &p_grp[4*k +: 4];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v   <= 1'b0;
            s1_g   <= '0;
            s1_p   <= '0;
            s1_cin <= 1'b0;
            s1_bg  <= '0;
            s1_bp  <= '0;
        end else if (s1_load) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_g   <= g_grp;
                s1_p   <= p_grp;
                s1_cin <= cin;
                s1_bg  <= bg_d;
                s1_bp  <= bp_d;
            end
        end
    end

    // Block carries, flattened to two-level sum-of-products
    always_comb begin
        cb[0] = s1_cin;
        cb[1] = s1_bg[0] | (s1_bp[0] & s1_cin);
        cb[2] = s1_bg[1] | (s1_bp[1] & s1_bg[0]) | (s1_bp[1] & s1_bp[0] & s1_cin);
        cb[3] = s1_bg[2] | (s1_bp[2] & s1_bg[1]) | (s1_bp[2] & s1_bp[1] & s1_bg[0])
              | (s1_bp[2] & s1_bp[1] & s1_bp[0] & s1_cin);
        cb[4] = s1_bg[3] | (s1_bp[3] & s1_bg[2]) | (s1_bp[3] & s1_bp[2] & s1_bg[1])
              | (s1_bp[3] & s1_bp[2] & s1_bp[1] & s1_bg[0])
              | (s1_bp[3] & s1_bp[2] & s1_bp[1] & s1_bp[0] & s1_cin);
        g_all_d = s1_bg[3] | (s1_bp[3] & s1_bg[2]) | (s1_bp[3] & s1_bp[2] & s1_bg[1])
                | (s1_bp[3] & s1_bp[2] & s1_bp[1] & s1_bg[0]);
        p_all_d = &s1_bp;
    end

    // Group carries inside each block from that block's incoming carry
    always_comb begin
        c_d = '0;
        for (int k = 0; k < 4; k++) begin
            c_d[4*k]   = cb[k];
            c_d[4*k+1] = s1_g[4*k] | (s1_p[4*k] & cb[k]);
            c_d[4*k+2] = s1_g[4*k+1] | (s1_p[4*k+1] & s1_g[4*k])
                       | (s1_p[4*k+1] & s1_p[4*k] & cb[k]);
            c_d[4*k+3] = s1_g[4*k+2] | (s1_p[4*k+2] & s1_g[4*k+1])
                       | (s1_p[4*k+2] & s1_p[4*k+1] & s1_g[4*k])
                       | (s1_p[4*k+2] & s1_p[4*k+1] & s1_p[4*k] & cb[k]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            c_grp     <= '0;
            cout      <= 1'b0;
            g_all     <= 1'b0;
            p_all     <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_v;
            if (s1_v) begin
                c_grp <= c_d;
                cout  <= cb[4];
                g_all <= g_all_d;
                p_all <= p_all_d;
            end
        end
    end

endmodule

// File: tb/tb_cla_group_carry_pipe.sv
// Bench for cla_group_carry_pipe: directed carry patterns, backpressure, reset, and randomized 64-bit adds.
module tb_cla_group_carry_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] g_grp;
    logic [15:0] p_grp;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] c_grp;
    logic        cout;
    logic        g_all;
    logic        p_all;

    typedef struct packed {
        logic [15:0] c;
        logic        co;
        logic        ga;
        logic        pa;
    } res_t;

    res_t cur_exp;
    res_t expq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    cla_group_carry_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .g_grp(g_grp), .p_grp(p_grp), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .c_grp(c_grp), .cout(cout), .g_all(g_all), .p_all(p_all)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Carry rippled group by group from generate/propagate
    function automatic res_t model_gp(input logic [15:0] g, input logic [15:0] p, input logic ci);
        res_t r;
        logic c;
        c = ci;
        for (int j = 0; j < 16; j++) begin
            r.c[j] = c;
            c = g[j] | (p[j] & c);
        end
        r.co = c;
        c = 1'b0;
        for (int j = 0; j < 16; j++) c = g[j] | (p[j] & c);
        r.ga = c;
        r.pa = &p;
        return r;
    endfunction

    // Carries read straight off integer sums of the operands
    function automatic res_t model_ab(input logic [63:0] a, input logic [63:0] b, input logic ci);
        res_t r;
        logic [63:0] m;
        logic [64:0] s;
        for (int j = 0; j < 16; j++) begin
            m = (64'd1 << (4 * j)) - 64'd1;
            s = {1'b0, a & m} + {1'b0, b & m} + {64'd0, ci};
            r.c[j] = s[4*j];
        end
        s = {1'b0, a} + {1'b0, b} + {64'd0, ci};
        r.co = s[64];
        s = {1'b0, a} + {1'b0, b};
        r.ga = s[64];
        r.pa = (s == {1'b0, {64{1'b1}}});
        return r;
    endfunction

    task automatic gp_of(input logic [63:0] a, input logic [63:0] b,
                         output logic [15:0] g, output logic [15:0] p);
        logic [4:0] t;
        for (int j = 0; j < 16; j++) begin
            t = {1'b0, a[4*j +: 4]} + {1'b0, b[4*j +: 4]};
            g[j] = t[4];
            p[j] = (t == 5'h0F);
        end
    endtask

    // Scoreboard and hold checker, sampled on the falling edge
    initial begin
        res_t held;
        res_t e;
        logic held_v;
        held_v = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_v = 1'b0;
                expq.delete();
            end else begin
                if (in_valid && in_ready) expq.push_back(cur_exp);
                if (held_v && out_valid) chk("hold_stable", {c_grp, cout, g_all, p_all}, held);
                held_v = out_valid && !out_ready;
                held = {c_grp, cout, g_all, p_all};
                if (out_valid && out_ready) begin
                    if (expq.size() == 0) begin
                        chk("spurious_out", 64'd1, 64'd0);
                    end else begin
                        e = expq.pop_front();
                        chk("c_grp", c_grp, e.c);
                        chk("cout", cout, e.co);
                        chk("g_all", g_all, e.ga);
                        chk("p_all", p_all, e.pa);
                    end
                end
            end
        end
    end

    task automatic one_shot(input string nm, input logic [15:0] g, input logic [15:0] p,
                            input logic ci, input res_t lit);
        int cnt;
        @(posedge clk); #1;
        g_grp = g; p_grp = p; cin = ci; in_valid = 1'b1; out_ready = 1'b1;
        cur_exp = model_gp(g, p, ci);
        chk({nm, "_model"}, cur_exp, lit);
        chk({nm, "_in_ready"}, in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 1;
        while (!out_valid && cnt < 10) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk({nm, "_latency"}, cnt, 2);
        chk({nm, "_result"}, {c_grp, cout, g_all, p_all}, lit);
    endtask

    task automatic set_rand_gp();
        g_grp = 16'($urandom);
        p_grp = 16'($urandom) & ~g_grp;
        cin = 1'($urandom_range(0, 1));
        cur_exp = model_gp(g_grp, p_grp, cin);
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] b;
        logic [15:0] g;
        logic [15:0] p;
        int acc;
        int cyc;

        // Reset with inputs presented
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        g_grp = 16'hFFFF; p_grp = 16'h0; cin = 1'b1; cur_exp = '0;
        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_outputs", {c_grp, cout, g_all, p_all}, 19'd0);
        chk("rst_in_ready", in_ready, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_out_valid", out_valid, 1'b0);
        rst = 1'b0; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_idle", out_valid, 1'b0);

        // Model pins against hand-derived values
        chk("model_ab_allprop", model_ab(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1), {16'hFFFF, 1'b1, 1'b0, 1'b1});
        chk("model_ab_gen0", model_ab(64'd8, 64'd8, 1'b0), {16'h0002, 1'b0, 1'b0, 1'b0});

        one_shot("full_prop", 16'h0000, 16'hFFFF, 1'b1, {16'hFFFF, 1'b1, 1'b0, 1'b1});
        one_shot("gen_ripple", 16'h0001, 16'hFFFE, 1'b0, {16'hFFFE, 1'b1, 1'b1, 1'b0});
        one_shot("kill", 16'h0000, 16'hFF7F, 1'b1, {16'h00FF, 1'b0, 1'b0, 1'b0});

        // Backpressure: three back-to-back sets against a stalled consumer
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; set_rand_gp();
        chk("bp_ready_a", in_ready, 1'b1);
        @(posedge clk); #1;
        set_rand_gp();
        chk("bp_ready_b", in_ready, 1'b1);
        @(posedge clk); #1;
        set_rand_gp();
        chk("bp_ready_c", in_ready, 1'b0);
        @(posedge clk); #1;
        chk("bp_ready_c_stall", in_ready, 1'b0);
        chk("bp_valid_stall", out_valid, 1'b1);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_comb", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_out_b", out_valid, 1'b1);
        @(posedge clk); #1;
        chk("bp_out_c", out_valid, 1'b1);
        @(posedge clk); #1;
        chk("bp_drained", out_valid, 1'b0);
        chk("bp_queue_empty", expq.size(), 0);

        // Reset one cycle after the second accept
        out_ready = 1'b0; in_valid = 1'b1; set_rand_gp();
        @(posedge clk); #1;
        set_rand_gp();
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_outputs", {c_grp, cout, g_all, p_all}, 19'd0);
        chk("midrst_in_ready", in_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_no_stale", out_valid, 1'b0);
        one_shot("after_rst", 16'h0001, 16'hFFFE, 1'b0, {16'hFFFE, 1'b1, 1'b1, 1'b0});

        // Randomized operands with random handshakes
        acc = 0;
        cyc = 0;
        while (acc < 10000 && cyc < 60000) begin
            @(posedge clk); #1;
            a = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: b = ~a;
                1: b = ~a ^ (64'd1 << $urandom_range(0, 63));
                default: b = {$urandom, $urandom};
            endcase
            cin = 1'($urandom_range(0, 1));
            gp_of(a, b, g, p);
            g_grp = g; p_grp = p;
            cur_exp = model_ab(a, b, cin);
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            cyc++;
        end
        chk("rand_accepts", acc, 10000);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rand_drained", expq.size(), 0);
        chk("rand_idle", out_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cla_group_carry_pipe.md
CLA_GROUP_CARRY_PIPE -- requirements
Module: cla_group_carry_pipe

Interface
REQ-001 No parameters SHALL exist; the block SHALL be fixed at 16 groups of 4 bits (64-bit adder).
REQ-002 clk  input  1  rising-edge clock; only clock.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  an operand set is presented.
REQ-005 in_ready  output  1  block accepts the set this cycle.
REQ-006 g_grp  input  16  group generate from each 4-bit slice; bit j = group j (bits 4j+3..4j).
REQ-007 p_grp  input  16  group propagate from each 4-bit slice.
REQ-008 cin  input  1  adder carry-in.
REQ-009 out_valid  output  1  result registers hold a valid result.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 c_grp  output  16  carry into group j; c_grp[0] equals the captured cin.
REQ-012 cout  output  1  carry out of group 15.
REQ-013 g_all  output  1  64-bit generate.
REQ-014 p_all  output  1  64-bit propagate (AND of all 16 p_grp bits).

Function
REQ-015 Transfers SHALL occur only on in_valid&in_ready (input) and out_valid&out_ready (output).
REQ-016 Stage 1 SHALL, on an input transfer, register g_grp, p_grp and cin, plus block terms BG[k], BP[k] for k=0..3 over groups 4k..4k+3, with the 4-group lookahead equations.
REQ-017 Stage 2 SHALL compute block carries from BG, BP and cin: CB[0]=cin, CB[k+1]=BG[k]|BP[k]&CB[k] expanded to two-level form.
REQ-018 Stage 2 SHALL compute group carries within each block from the registered g/p and CB[k], and register c_grp, cout, g_all and p_all.
REQ-019 Latency SHALL be exactly 2 cycles from input transfer to out_valid with no stall.
REQ-020 Throughput SHALL be one set per cycle when out_ready is held high.
REQ-021 Stage-valid flags s1_v and out_valid SHALL advance as follows: s2 loads when !out_valid|out_ready; s1 loads when !s1_v|s2 loads.
REQ-022 in_ready SHALL equal !s1_v | !out_valid | out_ready, and SHALL be combinational from out_ready only.
REQ-023 Bubbles SHALL collapse: an empty stage SHALL accept data even while downstream is stalled.
REQ-024 When out_valid=1 and out_ready=0, all outputs SHALL hold stable.
REQ-025 A stalled stage SHALL never be overwritten, and no transaction SHALL be dropped or duplicated.
REQ-026 Simultaneous output transfer and input transfer SHALL both complete in the same cycle.
REQ-027 Data registers MAY load when their stage is idle, and SHALL be ignored while the stage valid flag is 0.
REQ-028 Results SHALL equal the carries of a + b + cin for any a, b with g_grp/p_grp derived from them.

Reset
REQ-029 While rst=1, s1_v and out_valid SHALL be 0, and c_grp, cout, g_all and p_all SHALL be 0, independent of clk.
REQ-030 in_ready SHALL be 1 while rst=1 (pipeline empty); inputs presented during reset SHALL NOT be accepted.
REQ-031 Reset mid-operation SHALL discard all in-flight sets.
REQ-032 After reset deasserts, the first out_valid SHALL come exactly 2 cycles after the first input transfer.

Verification
REQ-033 Full propagate: g_grp=16'h0000, p_grp=16'hFFFF, cin=1 -> c_grp=16'hFFFF, cout=1, g_all=0, p_all=1, out_valid 2 cycles after transfer.
REQ-034 Generate ripple: g_grp=16'h0001, p_grp=16'hFFFE, cin=0 -> c_grp=16'hFFFE, cout=1, g_all=1, p_all=0.
REQ-035 Kill: g_grp=16'h0000, p_grp=16'hFF7F, cin=1 -> c_grp=16'h00FF, cout=0, p_all=0.
REQ-036 Backpressure: out_ready=0 with 3 back-to-back sets -> first two accepted, in_ready=0 on the third; out_ready=1 -> results delivered in order, once each, one per cycle.
REQ-037 Reset mid-flight: assert rst 1 cycle after the second accept -> out_valid=0 and outputs=0 immediately; no stale result after deassert.
REQ-038 Random: 10k sets of random a, b, cin with random in_valid/out_ready -> every c_grp and cout match a reference 64-bit addition, in order.
